// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state type, quadrant angle constants and
// the arctangent table common to the vectoring and rotation-mode CORDICs.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } cordic_state_t;

    // Binary angle: 2^32 is a full turn.
    localparam logic [31:0] ANG_90  = 32'h4000_0000;
    localparam logic [31:0] ANG_M90 = 32'hC000_0000;

    localparam int ATAN_ENTRIES = 30;

    // Fraction bits carried below the integer part of x/y so that y keeps
    // converging after x>>>i has dropped below one integer LSB.
    localparam int GUARD_BITS = 10;

    // round(atan(2^-i) / (2*pi) * 2^32)
    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = 32'h2000_0000;
            5'd1:    atan_lut = 32'h12E4_051D;
            5'd2:    atan_lut = 32'h09FB_385B;
            5'd3:    atan_lut = 32'h0511_11D4;
            5'd4:    atan_lut = 32'h028B_0D43;
            5'd5:    atan_lut = 32'h0145_D7E1;
            5'd6:    atan_lut = 32'h00A2_F61E;
            5'd7:    atan_lut = 32'h0051_7C55;
            5'd8:    atan_lut = 32'h0028_BE53;
            5'd9:    atan_lut = 32'h0014_5F2F;
            5'd10:   atan_lut = 32'h000A_2F98;
            5'd11:   atan_lut = 32'h0005_17CC;
            5'd12:   atan_lut = 32'h0002_8BE6;
            5'd13:   atan_lut = 32'h0001_45F3;
            5'd14:   atan_lut = 32'h0000_A2FA;
            5'd15:   atan_lut = 32'h0000_517D;
            5'd16:   atan_lut = 32'h0000_28BE;
            5'd17:   atan_lut = 32'h0000_145F;
            5'd18:   atan_lut = 32'h0000_0A30;
            5'd19:   atan_lut = 32'h0000_0518;
            5'd20:   atan_lut = 32'h0000_028C;
            5'd21:   atan_lut = 32'h0000_0146;
            5'd22:   atan_lut = 32'h0000_00A3;
            5'd23:   atan_lut = 32'h0000_0051;
            5'd24:   atan_lut = 32'h0000_0029;
            5'd25:   atan_lut = 32'h0000_0014;
            5'd26:   atan_lut = 32'h0000_000A;
            5'd27:   atan_lut = 32'h0000_0005;
            5'd28:   atan_lut = 32'h0000_0003;
            5'd29:   atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent ROM indexed by the micro-rotation number.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int idx_width = 4
) (
    input  logic [idx_width-1:0] idx,
    output logic [31:0]          atan
);

    // Table lookup; indices past the table return zero.
    always_comb begin
        atan = atan_lut(5'(idx));
    end

endmodule

// File: rtl/cordic_v.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, returns
// the uncompensated magnitude K*|v| and atan2(y, x) as a 32-bit binary angle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready high, waiting for a vector
// ROTATE | one micro-rotation per clock, iteration index idx_q
// DONE   | out_valid high, result held until out_ready
module cordic_v
    import cordic_pkg::*;
#(
    parameter int width = 16,
    parameter int iters = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [width-1:0] x_start,
    input  logic signed [width-1:0] y_start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [width+1:0]        mag_end,
    output logic [31:0]             angle_end
);

    localparam int DW = width + 2 + GUARD_BITS;
    localparam int IW = $clog2(iters + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(iters - 1);

    cordic_state_t state, state_nxt;

    logic signed [DW-1:0] x_ext, y_ext;
    logic signed [DW-1:0] x_pre, y_pre;
    logic signed [DW-1:0] x_q, y_q, x_sh, y_sh, x_nxt, y_nxt;
    logic [31:0]          z_pre, z_q, z_nxt, atan_i;
    logic [IW-1:0]        idx_q;
    logic                 zero_q;
    logic [width+1:0]     mag_rnd, mag_q;
    logic [31:0]          angle_q;
    logic                 accept, last_iter;

    assign accept    = in_valid && in_ready;
    assign last_iter = (state == ROTATE) && (idx_q == LAST_IDX);

    cordic_atan_rom #(.idx_width(IW)) u_atan_rom (
        .idx  (idx_q),
        .atan (atan_i)
    );

    assign x_ext = {{2{x_start[width-1]}}, x_start, {GUARD_BITS{1'b0}}};
    assign y_ext = {{2{y_start[width-1]}}, y_start, {GUARD_BITS{1'b0}}};

    // Pre-rotation by +/-90 deg folds left half-plane inputs into x >= 0.
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_start[width-1]) begin
            if (!y_start[width-1]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = ANG_90;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = ANG_M90;
            end
        end
    end

    // One micro-rotation through the shared shifter pair, steering y to zero.
    always_comb begin
        x_sh = x_q >>> idx_q;
        y_sh = y_q >>> idx_q;
        if (!y_q[DW-1]) begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_i;
        end else begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_i;
        end
    end

    // Magnitude rounded to integer LSBs from the last-iteration x.
    assign mag_rnd = x_nxt[DW-1:GUARD_BITS] + {{(width+1){1'b0}}, x_nxt[GUARD_BITS-1]};

    // Datapath registers: load on accept, iterate in ROTATE, latch result on last iteration.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            angle_q <= '0;
        end else if (accept) begin
            x_q    <= x_pre;
            y_q    <= y_pre;
            z_q    <= z_pre;
            idx_q  <= '0;
            zero_q <= (x_start == '0) && (y_start == '0);
        end else if (state == ROTATE) begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            z_q   <= z_nxt;
            idx_q <= idx_q + IW'(1);
            if (last_iter) begin
                mag_q   <= zero_q ? '0 : mag_rnd;
                angle_q <= zero_q ? '0 : z_nxt;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                 state_nxt = ROTATE;
            ROTATE:  if (last_iter)              state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Handshake and result outputs; reset forces the idle view immediately.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        mag_end   = '0;
        angle_end = '0;
        if (!reset) begin
            in_ready  = (state == IDLE);
            out_valid = (state == DONE);
            mag_end   = mag_q;
            angle_end = angle_q;
        end
    end

endmodule

// File: tb/tb_cordic_v.sv
// Scoreboard bench for cordic_v: expected results from a floating-point
// atan2/hypot model or fixed reference points, popped on each output handshake.
module tb_cordic_v;

    localparam int W = 16;
    localparam int N = 15;

    logic                clock = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_start, y_start;
    logic                out_valid;
    logic                out_ready;
    logic [W+1:0]        mag_end;
    logic [31:0]         angle_end;

    always #5 clock = ~clock;

    cordic_v #(.width(W), .iters(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_start   (x_start),
        .y_start   (y_start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_end   (mag_end),
        .angle_end (angle_end)
    );

    typedef struct {
        longint mag;
        longint ang;
        longint mag_tol;
        longint ang_tol;
        int     acc;
    } exp_t;

    exp_t   sb[$];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    int     n_sent = 0;
    int     n_out = 0;
    real    kgain;

    logic         prev_ov = 1'b0;
    logic         prev_or = 1'b0;
    logic [W+1:0] prev_mag = '0;
    logic [31:0]  prev_ang = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want,
                         input longint tol, input bit wrap32);
        longint d;
        n_checks++;
        if (wrap32) d = longint'(int'(got - want));
        else        d = got - want;
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d) tol %0d",
                      tag, got, got, want, want, tol);
    endtask

    function automatic void ref_model(input int x, input int y,
                                      output longint mag, output longint ang);
        real a;
        if (x == 0 && y == 0) begin
            mag = 0;
            ang = 0;
        end else begin
            mag = longint'(kgain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
            a   = $atan2(real'(y), real'(x)) / (2.0 * 3.14159265358979323846) * 4294967296.0;
            ang = longint'(a) & 64'hFFFF_FFFF;
        end
    endfunction

    // Offer one vector (caller sits just after a rising edge), push its
    // expectation at the accepting cycle, then withdraw in_valid.
    task automatic send(input int x, input int y, input longint m, input longint a,
                        input longint mt, input longint at, output int waited);
        exp_t e;
        bit   ok = 1'b0;
        in_valid = 1'b1;
        x_start  = W'(x);
        y_start  = W'(y);
        waited   = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clock);
            if (in_ready) begin
                e.mag = m; e.ang = a; e.mag_tol = mt; e.ang_tol = at; e.acc = cyc;
                sb.push_back(e);
                n_sent++;
                ok = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!ok) check("accept_timeout", 0, 1, 0, 0);
        @(posedge clock); #2;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input int x, input int y);
        longint m, a;
        int     w;
        ref_model(x, y, m, a);
        send(x, y, m, a, 3, 64'h2_0000, w);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", longint'(sb.size()), 0, 0, 0);
        @(posedge clock); #2;
    endtask

    // Output monitor: latency, hold-while-stalled, and scoreboard compare.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) check("spurious_out_valid", 1, 0, 0, 0);
                else                check("latency", longint'(cyc - sb[0].acc), N + 1, 0, 0);
            end
            if (out_valid && prev_ov && !prev_or) begin
                check("hold_mag", longint'(mag_end), longint'(prev_mag), 0, 0);
                check("hold_angle", longint'(angle_end), longint'(prev_ang), 0, 1);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("mag", longint'(mag_end), e.mag, e.mag_tol, 0);
                check("angle", longint'(angle_end), e.ang, e.ang_tol, 1);
                n_out++;
            end
        end
        prev_ov  <= out_valid && !reset;
        prev_or  <= out_ready;
        prev_mag <= mag_end;
        prev_ang <= angle_end;
    end

    int     sx[6] = '{1000, 0,    1000, -1000, -32768, 0};
    int     sy[6] = '{0,    1000, 1000, -1000, 0,      0};
    longint sm[6] = '{1647, 1647, 2329, 2329,  53961,  0};
    longint sa[6] = '{64'h0, 64'h4000_0000, 64'h2000_0000, 64'hA000_0000, 64'h8000_0000, 64'h0};
    int     bx[4] = '{-1000, 1000, 32767, -32768};
    int     by[4] = '{1000, -1000, 32767, -32768};

    initial begin
        int w, k, last, rx, ry;
        longint m, a;

        kgain = 1.0;
        for (int i = 0; i < N; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_start = '0; y_start = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", longint'(in_ready), 1, 0, 0);
        check("rst_out_valid", longint'(out_valid), 0, 0, 0);
        check("rst_mag", longint'(mag_end), 0, 0, 0);
        check("rst_angle", longint'(angle_end), 0, 0, 0);
        @(posedge clock); #2;
        reset = 1'b0;

        // Reference points, zero vector compared exactly.
        for (int i = 0; i < 6; i++) begin
            send(sx[i], sy[i], sm[i], sa[i],
                 (sm[i] == 0) ? 0 : 3, (sm[i] == 0) ? 0 : 64'h2_0000, w);
            wait_drain();
        end

        // Random vectors against the floating-point model.
        for (int i = 0; i < 6; i++) begin
            rx = int'($urandom_range(40000)) - 20000;
            ry = int'($urandom_range(40000)) - 20000;
            if (rx > -500 && rx < 500) rx = 700;
            send_model(rx, ry);
            wait_drain();
        end

        // Back-pressure: stall five cycles in DONE.
        out_ready = 1'b0;
        send_model(300, -700);
        k = 0;
        while (!out_valid && k < 100) begin @(negedge clock); k++; end
        if (!out_valid) check("bp_valid_timeout", 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_in_ready", longint'(in_ready), 0, 0, 0);
            check("bp_out_valid", longint'(out_valid), 1, 0, 0);
        end
        @(posedge clock); #2;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp_consumed", longint'(out_valid), 0, 0, 0);
        wait_drain();

        // Reset during iteration 7 discards the vector; next one accepts at once.
        send_model(1234, 567);
        repeat (7) @(posedge clock);
        #2;
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        check("midrst_out_valid", longint'(out_valid), 0, 0, 0);
        check("midrst_in_ready", longint'(in_ready), 1, 0, 0);
        @(posedge clock); #2;
        reset = 1'b0;
        send(1000, 0, 1647, 0, 3, 64'h2_0000, w);
        check("midrst_reaccept_wait", longint'(w), 0, 0, 0);
        wait_drain();
        repeat (40) @(posedge clock);
        #2;

        // Back-to-back: in_valid held high, accepts every N+2 cycles.
        in_valid = 1'b1;
        x_start = W'(bx[0]); y_start = W'(by[0]);
        k = 0; last = 0;
        for (int c = 0; c < 200 && k < 4; c++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_t e;
                ref_model(bx[k], by[k], m, a);
                e.mag = m; e.ang = a; e.mag_tol = 3; e.ang_tol = 64'h2_0000; e.acc = cyc;
                sb.push_back(e);
                n_sent++;
                if (k > 0) check("b2b_spacing", longint'(cyc - last), N + 2, 0, 0);
                last = cyc;
                k++;
                @(posedge clock); #2;
                if (k < 4) begin
                    x_start = W'(bx[k]); y_start = W'(by[k]);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        if (k < 4) check("b2b_timeout", longint'(k), 4, 0, 0);
        in_valid = 1'b0;
        wait_drain();

        check("outputs_seen", longint'(n_out), longint'(n_sent - 1), 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_v.md
CORDIC_V -- requirements
Module: cordic_v

Interface
REQ-001 SHALL have parameter width, default 16, meaning the signed input sample width.
REQ-002 SHALL have parameter iters, default 15, meaning the number of micro-rotations (1..30).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input vector is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a vector.
REQ-007 SHALL have ports x_start and y_start, input, width, signed vector components.
REQ-008 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream takes the result.
REQ-010 SHALL have port mag_end, output, width+2, unsigned, equal to K*sqrt(x^2+y^2) with K≈1.64676, gain not compensated.
REQ-011 SHALL have port angle_end, output, 32, signed binary angle where 2^32 = 360 deg, 0x40000000 = +90 deg and 0x80000000 = ±180 deg.

Function
REQ-012 SHALL implement CORDIC vectoring mode iteratively, one micro-rotation per clock, driving y to zero and accumulating atan2(y_start, x_start) in z.
REQ-013 SHALL use FSM states IDLE, ROTATE and DONE: IDLE→ROTATE on in_valid&&in_ready; ROTATE→DONE after iters iterations; DONE→IDLE on out_valid&&out_ready.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL apply pre-rotation on the accept edge: x>=0 gives (x0,y0,z0)=(x,y,0); x<0 with y>=0 gives (y,-x,0x40000000); x<0 with y<0 gives (-y,x,0xC0000000).
REQ-016 SHALL, in iteration i, when y_i>=0 set x+=y>>>i, y-=x>>>i and z+=atan[i], and otherwise set x-=y>>>i, y+=x>>>i and z-=atan[i], using the pre-update x and y.
REQ-017 SHALL hold x and y internally as width+2 signed bits so that neither -(-2^(width-1)) nor the K gain overflows, and SHALL let z wrap modulo 2^32.
REQ-018 SHALL take atan[i] = round(atan(2^-i)/2pi * 2^32), i.e. 0x20000000, 0x12E4051D, 0x09FB385B, ...
REQ-019 SHALL assert out_valid exactly iters+1 cycles after the accept edge, i.e. 16 cycles at the default iters.
REQ-020 SHALL hold mag_end and angle_end stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, for input (0,0), produce mag_end=0 and angle_end=0 via a zero flag captured at accept.
REQ-022 SHALL keep a maximum throughput of one vector per iters+2 cycles, with no overlap of operations.

Reset
REQ-023 SHALL, while reset=1, force the FSM to IDLE, in_ready=1, out_valid=0, mag_end=0 and angle_end=0.
REQ-024 SHALL, on reset asserted during ROTATE or DONE, discard the operation in progress, emit no output for it, and accept a new vector on the first cycle after reset deasserts.

Structure
REQ-025 SHALL take the atan table, the angle constants ANG_90 (0x40000000) and ANG_M90 (0xC0000000), and the FSM state typedef from shared package cordic_pkg, which is shared with the rotation-mode CORDIC.
REQ-026 SHALL contain exactly one sub-module, cordic_atan_rom, which maps the iteration index to atan[i] combinationally.
REQ-027 SHALL contain a single shifter datapath, reused across iterations, with an index counter of width ceil(log2(iters+1)).

Verification (tolerances: angle ±0x00020000, magnitude ±3 LSB)
REQ-028 SHALL cover (1000,0) → angle 0x00000000 and mag 1647; (0,1000) → angle 0x40000000 and mag 1647.
REQ-029 SHALL cover (1000,1000) → angle 0x20000000 and mag 2329; (-1000,-1000) → angle 0xA0000000 and mag 2329.
REQ-030 SHALL cover (-32768,0) → angle 0x80000000 and mag 53961 with no overflow; (0,0) → angle 0 and mag 0.
REQ-031 SHALL cover back-pressure: out_ready held 0 for 5 cycles in DONE → outputs unchanged, in_ready=0, and the result consumed on the first out_ready=1 cycle.
REQ-032 SHALL cover reset pulsed on iteration 7 → out_valid never asserts for that vector, and the next vector (1000,0) gives the REQ-028 result at accept+16.
REQ-033 SHALL cover back-to-back in_valid held high → accepts spaced exactly 17 cycles apart when out_ready=1.
